// File: rtl/i2c_config_sequencer_if.sv
// Bundles the table port, the I2C write-controller handshake and the status outputs
// of the configuration sequencer. The sequencer is the master side.
interface i2c_config_sequencer_if;
    logic        reinit;
    logic [7:0]  lut_index;
    logic [23:0] lut_data;
    logic [23:0] i2c_data;
    logic        i2c_go;
    logic        i2c_end;
    logic        i2c_ack;
    logic        busy;
    logic        config_done;
    logic        config_fail;
    logic [7:0]  err_count;

    modport master (
        input  reinit, lut_data, i2c_end, i2c_ack,
        output lut_index, i2c_data, i2c_go, busy, config_done, config_fail, err_count
    );

    modport slave (
        output reinit, lut_data, i2c_end, i2c_ack,
        input  lut_index, i2c_data, i2c_go, busy, config_done, config_fail, err_count
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks a {slave, register, data} table after power-up or re-init and issues one I2C write
// per entry, with NACK/timeout retry and done/fail status.
module i2c_config_sequencer #(
    parameter int unsigned LUT_SIZE   = 32,
    parameter int unsigned PWR_DELAY  = 50000,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned TIMEOUT    = 4096
) (
    input logic                    clock,
    input logic                    reset_n,
    i2c_config_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StPwrWait,
        StFetch,
        StStart,
        StWaitLow,
        StWaitEnd,
        StGap,
        StDone,
        StFail
    } state_e;

    localparam logic [7:0]  LastIndex = 8'(LUT_SIZE - 1);
    localparam logic [31:0] FetchLat  = 32'd2;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] retry_q, retry_d;
    logic [7:0]  index_q, index_d;
    logic [23:0] data_q, data_d;
    logic [7:0]  err_q, err_d;
    logic        gap_fetch_q, gap_fetch_d;
    logic        reinit_q;
    logic        reinit_rise;
    logic        attempt_failed;

    assign reinit_rise = bus.reinit & ~reinit_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StPwrWait;
            cnt_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            index_q     <= '0;
            data_q      <= '0;
            err_q       <= '0;
            gap_fetch_q <= 1'b0;
            reinit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            index_q     <= index_d;
            data_q      <= data_d;
            err_q       <= err_d;
            gap_fetch_q <= gap_fetch_d;
            reinit_q    <= bus.reinit;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q + 32'd1;
        tmo_d          = tmo_q + 32'd1;
        retry_d        = retry_q;
        index_d        = index_q;
        data_d         = data_q;
        err_d          = err_q;
        gap_fetch_d    = gap_fetch_q;
        attempt_failed = 1'b0;

        unique case (state_q)
            StPwrWait: begin
                if (cnt_q + 32'd1 >= PWR_DELAY) begin
                    state_d = StFetch;
                    index_d = '0;
                end
            end
            StFetch: begin
                // Two cycles of settle time let a registered ROM follow the index.
                if (cnt_q == FetchLat) begin
                    if (bus.lut_data[23:16] == 8'h00) begin
                        state_d = StDone;
                    end else begin
                        data_d  = bus.lut_data;
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                // tmo counts GO-high cycles, START included.
                tmo_d   = 32'd1;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                if (!bus.i2c_end) begin
                    state_d = StWaitEnd;
                end else if (tmo_q + 32'd1 >= TIMEOUT) begin
                    attempt_failed = 1'b1;
                end
            end
            StWaitEnd: begin
                if (bus.i2c_end) begin
                    if (bus.i2c_ack) begin
                        retry_d = '0;
                        if (index_q == LastIndex) begin
                            state_d = StDone;
                        end else begin
                            index_d     = index_q + 8'd1;
                            gap_fetch_d = 1'b1;
                            state_d     = StGap;
                        end
                    end else begin
                        attempt_failed = 1'b1;
                    end
                end else if (tmo_q + 32'd1 >= TIMEOUT) begin
                    attempt_failed = 1'b1;
                end
            end
            StGap: begin
                if (cnt_q + 32'd1 >= GAP_CYCLES) begin
                    state_d = gap_fetch_q ? StFetch : StStart;
                end
            end
            StDone, StFail: begin
                cnt_d = cnt_q;
                tmo_d = tmo_q;
            end
        endcase

        if (attempt_failed) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (retry_q < MAX_RETRY) begin
                retry_d     = retry_q + 32'd1;
                gap_fetch_d = 1'b0;
                state_d     = StGap;
            end else begin
                state_d = StFail;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if (reinit_rise) begin
            state_d = StPwrWait;
            cnt_d   = '0;
            index_d = '0;
            retry_d = '0;
            err_d   = '0;
        end
    end

    always_comb begin
        bus.i2c_go      = 1'b0;
        bus.busy        = 1'b1;
        bus.config_done = 1'b0;
        bus.config_fail = 1'b0;
        unique case (state_q)
            StStart, StWaitLow, StWaitEnd: bus.i2c_go = 1'b1;
            StDone: begin
                bus.busy        = 1'b0;
                bus.config_done = 1'b1;
            end
            StFail: begin
                bus.busy        = 1'b0;
                bus.config_fail = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.lut_index = index_q;
    assign bus.i2c_data  = data_q;
    assign bus.err_count = err_q;

endmodule
